// File: rtl/alu_exec_seq.sv
// -----------------------------------------------------------------------------
// alu_exec_seq
//   Multi-cycle execute sequencer for an MSP430X-style CPU. Accepts a decoded
//   Format-I instruction, fetches the source and destination operands over a
//   request/acknowledge port, presents them to an external combinational ALU,
//   latches the resulting SR flags, and writes the result back over a
//   valid/ready port. A repeat count re-runs the operation rpt_cnt+1 times,
//   feeding each result back in as the next destination operand.
//
//   Optional feature macro: ALU_EXEC_SEQ_ZC_EN
//     Adds input instr_zc, latched at accept. When set, the ALU carry input
//     is forced to 0 on every pass; sr_c still updates from the ALU.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   instr_valid/instr_ready        instruction handshake (ready only when idle)
//   instr[15:0], rpt_cnt           Format-I word and number of extra passes
//   instr_zc                       zero-carry repeat (only with the macro)
//   rd_req/rd_sel/rd_ack/rd_data   operand fetch (rd_sel 0 = src, 1 = dst)
//   alu_instr/src/dst, alu_*in     registered operands and flags to the ALU
//   alu_result, alu_c/v/n/z        combinational ALU result and flags
//   wb_valid/wb_data/wb_ready      result writeback handshake
//   sr_c/v/n/z                     architectural status flags
//   busy, done, err                status; done/err are one-cycle pulses
// -----------------------------------------------------------------------------
module alu_exec_seq #(
  parameter int DW    = 20,
  parameter int RPT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  input  logic [RPT_W-1:0] rpt_cnt,
`ifdef ALU_EXEC_SEQ_ZC_EN
  input  logic             instr_zc,
`endif
  output logic             instr_ready,
  output logic             rd_req,
  output logic             rd_sel,
  input  logic             rd_ack,
  input  logic [DW-1:0]    rd_data,
  output logic [15:0]      alu_instr,
  output logic [DW-1:0]    alu_src,
  output logic [DW-1:0]    alu_dst,
  output logic             alu_cin,
  output logic             alu_vin,
  output logic             alu_nin,
  output logic             alu_zin,
  input  logic [DW-1:0]    alu_result,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             alu_n,
  input  logic             alu_z,
  output logic             wb_valid,
  output logic [DW-1:0]    wb_data,
  input  logic             wb_ready,
  output logic             sr_c,
  output logic             sr_v,
  output logic             sr_n,
  output logic             sr_z,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_SRC, S_FETCH_DST, S_EXEC, S_WB, S_DONE
  } state_e;

  localparam logic [3:0]       OP_MOV  = 4'h4;
  localparam logic [3:0]       OP_CMP  = 4'h9;
  localparam logic [3:0]       OP_BIT  = 4'hB;
  localparam logic [RPT_W-1:0] RPT_ONE = {{(RPT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [15:0]      instr_q, instr_d;
  logic [DW-1:0]    src_q, src_d, dst_q, dst_d, wb_data_q, wb_data_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             illegal_q, illegal_d;
  logic             sr_c_q, sr_c_d, sr_v_q, sr_v_d, sr_n_q, sr_n_d, sr_z_q, sr_z_d;
  logic             instr_ready_q, instr_ready_d, rd_req_q, rd_req_d, rd_sel_q, rd_sel_d;
  logic             wb_valid_q, wb_valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
`ifdef ALU_EXEC_SEQ_ZC_EN
  logic             zc_q, zc_d;
`endif

  logic [3:0] opc;
  logic       no_wb;
  assign opc   = instr_q[15:12];
  // CMP and BIT only update flags, so they never visit WB.
  assign no_wb = (opc == OP_CMP) || (opc == OP_BIT);

  // NOTE: every *_d gets its hold value first so no path through the case
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    src_d     = src_q;
    dst_d     = dst_q;
    wb_data_d = wb_data_q;
    rpt_d     = rpt_q;
    illegal_d = illegal_q;
    sr_c_d    = sr_c_q;
    sr_v_d    = sr_v_q;
    sr_n_d    = sr_n_q;
    sr_z_d    = sr_z_q;
`ifdef ALU_EXEC_SEQ_ZC_EN
    zc_d      = zc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d   = instr;
          rpt_d     = rpt_cnt;
          // Opcodes 0..3 are not Format-I: report and retire without side effects.
          illegal_d = (instr[15:14] == 2'b00);
`ifdef ALU_EXEC_SEQ_ZC_EN
          zc_d      = instr_zc;
`endif
          state_d   = illegal_d ? S_DONE : S_FETCH_SRC;
        end
      end
      S_FETCH_SRC: begin
        if (rd_ack) begin
          src_d   = rd_data;
          state_d = (opc == OP_MOV) ? S_EXEC : S_FETCH_DST;
        end
      end
      S_FETCH_DST: begin
        if (rd_ack) begin
          dst_d   = rd_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wb_data_d = alu_result;
        sr_c_d    = alu_c;
        sr_v_d    = alu_v;
        sr_n_d    = alu_n;
        sr_z_d    = alu_z;
        if (!no_wb) begin
          state_d = S_WB;
        end else if (rpt_q != '0) begin
          // Flag-only repeats re-run on the same operands.
          rpt_d   = rpt_q - RPT_ONE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WB: begin
        if (wb_ready) begin
          if (rpt_q != '0) begin
            rpt_d   = rpt_q - RPT_ONE;
            dst_d   = wb_data_q;
            state_d = S_EXEC;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    instr_ready_d = (state_d == S_IDLE);
    rd_req_d      = (state_d == S_FETCH_SRC) || (state_d == S_FETCH_DST);
    rd_sel_d      = (state_d == S_FETCH_DST);
    wb_valid_d    = (state_d == S_WB);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    err_d         = (state_d == S_DONE) && illegal_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      wb_data_q     <= '0;
      rpt_q         <= '0;
      illegal_q     <= 1'b0;
      sr_c_q        <= 1'b0;
      sr_v_q        <= 1'b0;
      sr_n_q        <= 1'b0;
      sr_z_q        <= 1'b0;
      instr_ready_q <= 1'b1;
      rd_req_q      <= 1'b0;
      rd_sel_q      <= 1'b0;
      wb_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
`ifdef ALU_EXEC_SEQ_ZC_EN
      zc_q          <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      wb_data_q     <= wb_data_d;
      rpt_q         <= rpt_d;
      illegal_q     <= illegal_d;
      sr_c_q        <= sr_c_d;
      sr_v_q        <= sr_v_d;
      sr_n_q        <= sr_n_d;
      sr_z_q        <= sr_z_d;
      instr_ready_q <= instr_ready_d;
      rd_req_q      <= rd_req_d;
      rd_sel_q      <= rd_sel_d;
      wb_valid_q    <= wb_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
`ifdef ALU_EXEC_SEQ_ZC_EN
      zc_q          <= zc_d;
`endif
    end
  end

  assign instr_ready = instr_ready_q;
  assign rd_req      = rd_req_q;
  assign rd_sel      = rd_sel_q;
  assign alu_instr   = instr_q;
  assign alu_src     = src_q;
  assign alu_dst     = dst_q;
`ifdef ALU_EXEC_SEQ_ZC_EN
  assign alu_cin     = zc_q ? 1'b0 : sr_c_q;
`else
  assign alu_cin     = sr_c_q;
`endif
  assign alu_vin     = sr_v_q;
  assign alu_nin     = sr_n_q;
  assign alu_zin     = sr_z_q;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign sr_c        = sr_c_q;
  assign sr_v        = sr_v_q;
  assign sr_n        = sr_n_q;
  assign sr_z        = sr_z_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
